// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Brief    : Inserts immediates into RV64 instruction templates; LI mode emits
//            a LUI(+ADDIW) pair for a signed 32-bit constant.
// Revision : 1.0
// ============================================================================

package CorePack;
    typedef logic [63:0] data_t;
    typedef enum logic [2:0] {
        IMM0   = 3'd0,
        I_IMM  = 3'd1,
        S_IMM  = 3'd2,
        B_IMM  = 3'd3,
        U_IMM  = 3'd4,
        UJ_IMM = 3'd5
    } imm_op_enum;
endpackage

module imm_encoder #(
    parameter int INST_W = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_li,
    input  CorePack::imm_op_enum in_imm_op,
    input  CorePack::data_t      in_imm,
    input  logic [INST_W-1:0]    in_tmpl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INST_W-1:0]    out_inst,
    output logic                 out_err,
    output logic                 out_last
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        HI    = 2'd2
    } state_t;

    state_t              state_q;
    logic [INST_W-1:0]   inst_q;
    logic [INST_W-1:0]   pend_q;
    logic                err_q;
    logic                last_q;

    logic [INST_W-1:0]   inst_d;
    logic                err_d;
    logic                last_d;
    logic                two_beat_d;
    logic                accept;

    logic                fit12;
    logic                fit13;
    logic                fit21;
    logic                fit32;
    logic [31:0]         li_sum;
    logic [4:0]          rd;
    logic [INST_W-1:0]   lui_inst;
    logic [INST_W-1:0]   addiw_inst;

    assign fit12 = (in_imm == {{52{in_imm[11]}}, in_imm[11:0]});
    assign fit13 = (in_imm == {{51{in_imm[12]}}, in_imm[12:0]});
    assign fit21 = (in_imm == {{43{in_imm[20]}}, in_imm[20:0]});
    assign fit32 = (in_imm == {{32{in_imm[31]}}, in_imm[31:0]});

    // Rounding by 0x800 compensates for ADDIW sign-extending its 12-bit field;
    // the wrap at 0x7FFFF800 is harmless because ADDIW works on 32 bits.
    assign li_sum     = in_imm[31:0] + 32'h0000_0800;
    assign rd         = in_tmpl[11:7];
    assign lui_inst   = {li_sum[31:12], rd, 7'b0110111};
    assign addiw_inst = {in_imm[11:0], rd, 3'b000, rd, 7'b0011011};

    always_comb begin
        inst_d     = in_tmpl;
        err_d      = 1'b0;
        last_d     = 1'b1;
        two_beat_d = 1'b0;
        if (in_li) begin
            inst_d     = lui_inst;
            err_d      = !fit32;
            two_beat_d = fit32 && (in_imm[11:0] != 12'h000);
            last_d     = !two_beat_d;
        end else begin
            case (in_imm_op)
                CorePack::I_IMM: begin
                    inst_d = {in_imm[11:0], in_tmpl[19:0]};
                    err_d  = !fit12;
                end
                CorePack::S_IMM: begin
                    inst_d = {in_imm[11:5], in_tmpl[24:12], in_imm[4:0], in_tmpl[6:0]};
                    err_d  = !fit12;
                end
                CorePack::B_IMM: begin
                    inst_d = {in_imm[12], in_imm[10:5], in_tmpl[24:12],
                              in_imm[4:1], in_imm[11], in_tmpl[6:0]};
                    err_d  = in_imm[0] || !fit13;
                end
                CorePack::U_IMM: begin
                    inst_d = {in_imm[31:12], in_tmpl[11:0]};
                    err_d  = (in_imm[11:0] != 12'h000) || !fit32;
                end
                CorePack::UJ_IMM: begin
                    inst_d = {in_imm[20], in_imm[10:1], in_imm[11],
                              in_imm[19:12], in_tmpl[11:0]};
                    err_d  = in_imm[0] || !fit21;
                end
                default: begin
                    inst_d = in_tmpl;
                end
            endcase
        end
    end

    assign in_ready = rstn && (state_q != HI) && ((state_q == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            inst_q  <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            inst_q  <= inst_d;
            err_q   <= err_d;
            last_q  <= last_d;
            pend_q  <= addiw_inst;
            state_q <= two_beat_d ? HI : ONE;
        end else if (out_ready) begin
            case (state_q)
                HI: begin
                    inst_q  <= pend_q;
                    err_q   <= 1'b0;
                    last_q  <= 1'b1;
                    state_q <= ONE;
                end
                ONE:     state_q <= EMPTY;
                default: state_q <= state_q;
            endcase
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign out_inst  = inst_q;
    assign out_err   = err_q;
    assign out_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// Testbench for imm_encoder: directed scenarios plus a randomized run scored
// against an arithmetic reference model.
module tb_imm_encoder;
    import CorePack::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_li = 1'b0;
    imm_op_enum  in_imm_op = IMM0;
    data_t       in_imm = '0;
    logic [31:0] in_tmpl = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;

    int n_checks = 0;
    int n_fail   = 0;

    imm_encoder #(.INST_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_li     (in_li),
        .in_imm_op (in_imm_op),
        .in_imm    (in_imm),
        .in_tmpl   (in_tmpl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic bit fits(input longint s, input int b);
        longint lim;
        lim = longint'(1) << (b - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    // Beat format: {err, last, inst}
    function automatic void model(input logic li, input logic [2:0] op, input logic [63:0] imm,
                                  input logic [31:0] tmpl, output int n,
                                  output logic [33:0] b0, output logic [33:0] b1);
        longint s, u32, hi, lo, rd, t;
        logic [31:0] w;
        logic err;
        s = longint'(imm);
        t = longint'(tmpl);
        u32 = s & 64'hFFFF_FFFF;
        n = 1; b1 = '0; err = 1'b0; w = tmpl;
        if (li) begin
            rd  = (t >> 7) & 31;
            hi  = ((u32 + 2048) >> 12) & 64'hF_FFFF;
            lo  = s & 64'hFFF;
            err = !fits(s, 32);
            w   = 32'(hi * 4096 + rd * 128 + 'h37);
            if (!err && lo != 0) begin
                n  = 2;
                b0 = {1'b0, 1'b0, w};
                b1 = {1'b0, 1'b1, 32'(lo * 1048576 + rd * 32768 + rd * 128 + 'h1B)};
                return;
            end
        end else begin
            case (op)
                3'd1: begin
                    err = !fits(s, 12);
                    w = 32'((s & 'hFFF) * 1048576 + (t & 'hFFFFF));
                end
                3'd2: begin
                    err = !fits(s, 12);
                    w = 32'((((s >> 5) & 'h7F) << 25) | (t & 'h01FFF07F) | ((s & 31) << 7));
                end
                3'd3: begin
                    err = ((s & 1) != 0) || !fits(s, 13);
                    w = 32'((((s >> 12) & 1) << 31) | (((s >> 5) & 63) << 25) | (t & 'h01FFF07F)
                            | (((s >> 1) & 15) << 8) | (((s >> 11) & 1) << 7));
                end
                3'd4: begin
                    err = ((s & 'hFFF) != 0) || !fits(s, 32);
                    w = 32'((s & 'hFFFFF000) | (t & 'hFFF));
                end
                3'd5: begin
                    err = ((s & 1) != 0) || !fits(s, 21);
                    w = 32'((((s >> 20) & 1) << 31) | (((s >> 1) & 1023) << 21) | (((s >> 11) & 1) << 20)
                            | (((s >> 12) & 255) << 12) | (t & 'hFFF));
                end
                default: w = tmpl;
            endcase
        end
        b0 = {err, 1'b1, w};
    endfunction

    task automatic issue(input logic li, input logic [2:0] op, input logic [63:0] imm, input logic [31:0] tmpl);
        @(negedge clk);
        in_li = li; in_imm_op = imm_op_enum'(op); in_imm = imm; in_tmpl = tmpl;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst, in_ready} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b e=%b l=%b inst=%h rdy=%b, want all zero",
                     out_valid, out_err, out_last, out_inst, in_ready);
        end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_i_imm();
        issue(1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0513);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst} !== {3'b101, 32'hFFF00513}) begin
            n_fail++;
            $display("FAIL i_imm: got v=%b e=%b l=%b inst=%h, want v=1 e=0 l=1 inst=fff00513",
                     out_valid, out_err, out_last, out_inst);
        end
        drain();
    endtask

    task automatic test_b_imm();
        issue(1'b0, 3'd3, -64'sd4, 32'h0000_0063);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst} !== {3'b101, 32'hFE000EE3}) begin
            n_fail++;
            $display("FAIL b_imm_neg4: got v=%b e=%b l=%b inst=%h, want v=1 e=0 l=1 inst=fe000ee3",
                     out_valid, out_err, out_last, out_inst);
        end
        drain();
        issue(1'b0, 3'd3, 64'd3, 32'h0000_0063);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst} !== {3'b111, 32'h00000163}) begin
            n_fail++;
            $display("FAIL b_imm_odd: got v=%b e=%b l=%b inst=%h, want v=1 e=1 l=1 inst=00000163",
                     out_valid, out_err, out_last, out_inst);
        end
        drain();
    endtask

    task automatic test_li();
        issue(1'b1, 3'd0, 64'h1234_5678, 32'h0000_0500);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst, in_ready} !== {3'b100, 32'h12345537, 1'b0}) begin
            n_fail++;
            $display("FAIL li_lui: got v=%b e=%b l=%b inst=%h rdy=%b, want v=1 e=0 l=0 inst=12345537 rdy=0",
                     out_valid, out_err, out_last, out_inst, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst} !== {3'b101, 32'h6785051B}) begin
            n_fail++;
            $display("FAIL li_addiw: got v=%b e=%b l=%b inst=%h, want v=1 e=0 l=1 inst=6785051b",
                     out_valid, out_err, out_last, out_inst);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL li_done: got out_valid=%b want 0", out_valid);
        end
        issue(1'b1, 3'd0, 64'h7FFF_F800, 32'h0000_0500);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst} !== {3'b100, 32'h80000537}) begin
            n_fail++;
            $display("FAIL li_wrap_lui: got v=%b e=%b l=%b inst=%h, want v=1 e=0 l=0 inst=80000537",
                     out_valid, out_err, out_last, out_inst);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst} !== {3'b101, 32'h8005051B}) begin
            n_fail++;
            $display("FAIL li_wrap_addiw: got v=%b e=%b l=%b inst=%h, want v=1 e=0 l=1 inst=8005051b",
                     out_valid, out_err, out_last, out_inst);
        end
        drain();
        issue(1'b1, 3'd0, 64'h0000_1000, 32'h0000_0500);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst} !== {3'b101, 32'h00001537}) begin
            n_fail++;
            $display("FAIL li_single: got v=%b e=%b l=%b inst=%h, want v=1 e=0 l=1 inst=00001537",
                     out_valid, out_err, out_last, out_inst);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL li_single_done: got out_valid=%b want 0", out_valid);
        end
        issue(1'b0, 3'd4, 64'h8000_0000, 32'h0000_0037);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, out_last, out_inst} !== {3'b111, 32'h80000037}) begin
            n_fail++;
            $display("FAIL u_imm_range: got v=%b e=%b l=%b inst=%h, want v=1 e=1 l=1 inst=80000037",
                     out_valid, out_err, out_last, out_inst);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        logic [31:0] want;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c < 5);
            in_valid  = (sent < 4);
            in_li = 1'b0; in_imm_op = I_IMM; in_tmpl = 32'h0000_0013;
            in_imm = 64'(sent + 1);
            #1;
            want = 32'((recv + 1) * 1048576 + 'h13);
            if (out_valid && !out_ready) begin
                n_checks++;
                if (out_inst !== want || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_stall: got inst=%h rdy=%b, want inst=%h rdy=0", out_inst, in_ready, want);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (recv >= 4 || {out_err, out_last, out_inst} !== {2'b01, want}) begin
                    n_fail++;
                    $display("FAIL b2b_order: beat %0d got e=%b l=%b inst=%h, want e=0 l=1 inst=%h",
                             recv, out_err, out_last, out_inst, want);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (recv != 4 || sent != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d, want 4 and 4", sent, recv);
        end
    endtask

    task automatic test_random();
        logic [33:0] exp_q[$];
        logic [33:0] b0, b1, head;
        logic [31:0] r;
        int n, nq;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            r = $urandom;
            case ($urandom_range(0, 4))
                0: in_imm = 64'(longint'($urandom_range(0, 8191)) - 4096);
                1: in_imm = {$urandom, $urandom};
                2: in_imm = {{32{r[31]}}, r};
                3: in_imm = 64'(longint'($urandom_range(0, 2097151)) - 1048576);
                default: in_imm = {{32{r[31]}}, r[31:12], 12'h000};
            endcase
            in_imm_op = imm_op_enum'($urandom_range(0, 5));
            in_li     = ($urandom_range(0, 3) == 0);
            in_tmpl   = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            nq = exp_q.size();
            n_checks++;
            if (out_valid !== (nq != 0) || in_ready !== ((nq == 0) || (nq == 1 && out_ready))) begin
                n_fail++;
                $display("FAIL rand_flow: cycle %0d got v=%b rdy=%b with %0d beats outstanding",
                         c, out_valid, in_ready, nq);
            end
            if (out_valid && out_ready && nq != 0) begin
                head = exp_q.pop_front();
                n_checks++;
                if ({out_err, out_last, out_inst} !== head) begin
                    n_fail++;
                    $display("FAIL rand_beat: cycle %0d got e=%b l=%b inst=%h, want e=%b l=%b inst=%h",
                             c, out_err, out_last, out_inst, head[33], head[32], head[31:0]);
                end
            end
            if (in_valid && in_ready) begin
                model(in_li, 3'(in_imm_op), in_imm, in_tmpl, n, b0, b1);
                exp_q.push_back(b0);
                if (n == 2) exp_q.push_back(b1);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            #1;
            if (out_valid) begin
                head = exp_q.pop_front();
                n_checks++;
                if ({out_err, out_last, out_inst} !== head) begin
                    n_fail++;
                    $display("FAIL rand_drain: got e=%b l=%b inst=%h, want e=%b l=%b inst=%h",
                             out_err, out_last, out_inst, head[33], head[32], head[31:0]);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d beats undelivered, want 0", exp_q.size());
        end
        drain();
    endtask

    task automatic test_reset_mid_li();
        issue(1'b1, 3'd0, 64'h1234_5678, 32'h0000_0500);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_last} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_li_hi: got v=%b l=%b, want v=1 l=0", out_valid, out_last);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_inst} !== 34'h0) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b rdy=%b inst=%h, want 0 0 00000000", out_valid, in_ready, out_inst);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b want 1", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_addiw: cycle %0d got out_valid=%b want 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_imm();
        test_b_imm();
        test_li();
        test_back_to_back();
        test_random();
        test_reset_mid_li();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Encoder for the immediate-decode direction. Takes a 32-bit instruction template plus a data_t immediate and a CorePack::imm_op_enum format, and emits the encoded RV64 instruction word.
- Also materializes a 32-bit signed constant as a LUI + ADDIW pair (LI mode), emitted over two output beats.
- Used by the boot/debug instruction injector and by test-program generators that feed the core's fetch path.
- Valid/ready on both sides, with a registered output and one pending-beat register.

Parameters:
- INST_W, 32, instruction word width (fixed; must not be overridden).

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_li  input  1  1 = LI mode (in_imm_op ignored)
- in_imm_op  input  CorePack::imm_op_enum  immediate format: IMM0, I_IMM, S_IMM, B_IMM, U_IMM, UJ_IMM
- in_imm  input  CorePack::data_t  immediate value (64-bit, signed)
- in_tmpl  input  32  template: opcode/rd/rs1/rs2/funct fields (LI mode uses only [11:7] = rd)
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts beat
- out_inst  output  32  encoded instruction
- out_err  output  1  immediate not representable in the selected format
- out_last  output  1  final beat of the request

Behaviour:
- Reset (async, rstn=0):
  - out_valid=0, out_inst=0, out_err=0, out_last=0.
  - Pending beat cleared; in_ready=0 while rstn=0.
  - Reset mid-LI discards the pending ADDIW; no beat is emitted after release.
- Handshake:
  - in_ready = !pending_valid && (!out_valid || out_ready).
  - Accepted request appears on out_* the next cycle (latency 1). Full throughput of 1 request/cycle for single-beat ops.
  - While out_valid && !out_ready, out_inst/out_err/out_last are held stable.
- States: EMPTY (out_valid=0), ONE (single or final beat held), HI (LUI held, ADDIW pending).
  - EMPTY --accept--> ONE or HI.
  - ONE --out_ready & accept--> ONE or HI; --out_ready & !in_valid--> EMPTY.
  - HI --out_ready--> ONE (ADDIW loaded, out_last=1); no input accepted while in HI.
- Encoding, non-LI. Template bits outside the format's immediate field pass through; immediate-field bits are overwritten.
  - IMM0: out_inst=in_tmpl; out_err=0.
  - I_IMM: [31:20]=imm[11:0]. err unless imm == sext(imm[11:0]).
  - S_IMM: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range rule as I_IMM.
  - B_IMM: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. err if imm[0]=1 or imm != sext(imm[12:0]).
  - U_IMM: [31:12]=imm[31:12]. err if imm[11:0]!=0 or imm != sext(imm[31:0]).
  - UJ_IMM: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. err if imm[0]=1 or imm != sext(imm[20:0]).
  - On err the truncated encoding is still emitted with out_err=1. out_last=1 always.
- LI mode:
  - err if imm != sext(imm[31:0]); on err emit a single beat, LUI form, out_err=1, out_last=1.
  - hi = (imm[31:0] + 32'h800)[31:12], modulo 2^32; lo = imm[11:0].
  - Beat 1: LUI rd,hi = {hi, rd, 7'b0110111}.
  - Beat 2: ADDIW rd,rd,lo = {lo, rd, 3'b000, rd, 7'b0011011}.
  - If lo==0: LUI only, out_last=1. Otherwise LUI beat has out_last=0 and ADDIW beat has out_last=1.
  - hi wraps for imm=0x7FFFF800 (hi=0x80000). This is correct because ADDIW is 32-bit.
- Simultaneous out_ready and in_valid in ONE: the new beat replaces the old one in the same edge, with no bubble.

Test Plan:
- I_IMM, tmpl=0x00000513, imm=0xFFFF_FFFF_FFFF_FFFF, out_ready=1 -> next cycle out_inst=0xFFF00513, err=0, last=1.
- B_IMM, tmpl=0x00000063, imm=-4 -> 0xFE000EE3, err=0; then imm=3 -> out_err=1.
- LI, tmpl rd=10, imm=0x12345678 -> beats 0x12345537 (last=0) then 0x6785051B (last=1). in_ready=0 during the HI cycle.
- LI imm=0x7FFFF800 -> 0x80000537 then 0x8005051B. LI imm=0x1000 -> single beat 0x00001537, last=1. U_IMM imm=0x80000000 -> out_err=1.
- Back-to-back 4 I_IMM requests with out_ready held 0 for 3 cycles mid-stream -> out_inst stable, in_ready=0 while stalled, all 4 emitted in order, none dropped or duplicated.
- rstn asserted while in HI (imm=0x12345678) -> out_valid=0 immediately, asynchronously. After release, no ADDIW beat is emitted and in_ready=1.
